// File: rtl/rr_arbiter4_pkg.sv
// Shared constants, FSM encoding and one-hot helper for the 4-way round-robin arbiter.
package rr_arbiter4_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4_priority_pick4.sv
// Combinational masked lowest-set-bit picker: search starts at bit ptr, falls back
// to the whole request vector when nothing at or above ptr is requesting.
module priority_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] onehot
);

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] masked_low;
  logic [NUM_REQ-1:0] req_low;

  // mask keeps bits ptr..3
  assign mask       = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
  assign masked     = req & mask;
  assign masked_low = masked & (~masked + NUM_REQ'(1));
  assign req_low    = req & (~req + NUM_REQ'(1));
  assign onehot     = (masked != '0) ? masked_low : req_low;

endmodule

// File: rtl/rr_arbiter4.sv
// Registered round-robin arbiter for 4 requesters with bounded grant tenure.
//  state | meaning
//  IDLE  | no grant outstanding, arbitrate from ptr on any request
//  BUSY  | grant held; release on drop or after MAX_HOLD cycles, re-arbitrate same edge
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GNT,
  output logic               GNT_VALID,
  output logic [ID_W-1:0]    GNT_ID
);

  state_t             state, state_nxt;
  logic [ID_W-1:0]    ptr, ptr_nxt;
  logic [CNT_W-1:0]   hold_cnt, cnt_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [ID_W-1:0]    pick_ptr;
  logic [NUM_REQ-1:0] pick;

  // on release the search starts just after the current holder, wrapping 3 -> 0
  assign pick_ptr = (state == BUSY) ? GNT_ID + ID_W'(1) : ptr;

  priority_pick4 u_pick (
    .req    (REQ),
    .ptr    (pick_ptr),
    .onehot (pick)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = hold_cnt;
    gnt_nxt   = GNT;
    unique case (state)
      IDLE: begin
        if (REQ != '0) begin
          gnt_nxt   = pick;
          cnt_nxt   = CNT_W'(1);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (REQ[GNT_ID] && (hold_cnt < CNT_W'(MAX_HOLD))) begin
          cnt_nxt = hold_cnt + CNT_W'(1);
        end else begin
          ptr_nxt = GNT_ID + ID_W'(1);
          gnt_nxt = pick;
          if (pick != '0) begin
            cnt_nxt = CNT_W'(1);
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      GNT       <= '0;
      GNT_VALID <= 1'b0;
      GNT_ID    <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= cnt_nxt;
      GNT       <= gnt_nxt;
      GNT_VALID <= |gnt_nxt;
      GNT_ID    <= onehot_to_idx(gnt_nxt);
    end
  end

endmodule
